cdr_frame_sync: RTL and testbench

CDR_FRAME_SYNC -- requirements
Module: cdr_frame_sync

---
 rtl/cdr_frame_sync.sv | 181 ++++++++++++++++++
 tb/tb_cdr_frame_sync.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : cdr_frame_sync
// Description : Bit-serial frame synchroniser behind a CDR. Hunts for the
//               sync byte at every bit position, verifies it over several
//               frames, then deframes payload bytes (MSB first) while
//               flywheeling through isolated sync misses.
//               Optional macro CDR_FRAME_SYNC_ERRCNT_EN enables the
//               saturating sync-miss counter on err_cnt (otherwise err_cnt=0).
// Revision    : 1.0 - initial release
// ============================================================================
module cdr_frame_sync #(
    parameter logic [7:0] SYNC_WORD   = 8'hD5,
    parameter int         FRAME_BYTES = 4,
    parameter int         VERIFY_N    = 2,
    parameter int         MISS_N      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_vld,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       sof,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] err_cnt
);

    // Frame length in bits, including the trailing sync slot
    localparam int c_frame_bits = (FRAME_BYTES + 1) * 8;
    localparam int c_cnt_w      = $clog2(c_frame_bits);

    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_pay_bits = c_cnt_w'(FRAME_BYTES * 8);
    localparam logic [c_cnt_w-1:0] c_first_end = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [2:0]         c_verify_n = 3'(VERIFY_N);
    localparam logic [2:0]         c_miss_n   = 3'(MISS_N);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    // Only the seven most recent bits are needed: the incoming bit completes
    // the 8-bit window, so the oldest shift-register bit never matters.
    logic [6:0]         r_sr;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [2:0]         r_hit;
    logic [2:0]         r_miss;
    logic [7:0]         r_byte_out;
    logic               r_byte_vld;
    logic               r_sof;
    logic               r_locked;

    logic [7:0]         w_byte;
    logic               w_match;
    logic               w_byte_end;
    logic               w_payload;
    logic               w_slot;
    logic               w_first;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [2:0]         w_hit_inc;
    logic [2:0]         w_miss_inc;

    assign w_byte     = {r_sr, bit_in};
    assign w_match    = (w_byte == SYNC_WORD);
    assign w_byte_end = (r_bit_cnt[2:0] == 3'd7);
    assign w_payload  = (r_bit_cnt < c_pay_bits);
    assign w_slot     = (r_bit_cnt == c_last_bit);
    assign w_first    = (r_bit_cnt == c_first_end);
    assign w_cnt_next = w_slot ? '0 : (r_bit_cnt + c_cnt_one);
    assign w_hit_inc  = r_hit + 3'd1;
    assign w_miss_inc = r_miss + 3'd1;

    // Shift register, frame counter, acquisition FSM and byte output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_hit      <= '0;
            r_miss     <= '0;
            r_byte_out <= '0;
            r_byte_vld <= 1'b0;
            r_sof      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_sof      <= 1'b0;
            if (bit_vld) begin
                r_sr <= w_byte[6:0];
            end
            case (r_state)
                ST_HUNT: begin
                    if (bit_vld && w_match) begin
                        r_state   <= ST_VERIFY;
                        r_bit_cnt <= '0;
                        r_hit     <= '0;
                    end
                end
                ST_VERIFY: begin
                    if (bit_vld) begin
                        r_bit_cnt <= w_cnt_next;
                        if (w_slot) begin
                            if (w_match) begin
                                r_hit <= w_hit_inc;
                                if (w_hit_inc == c_verify_n) begin
                                    r_state  <= ST_LOCKED;
                                    r_locked <= 1'b1;
                                    r_miss   <= '0;
                                end
                            end else begin
                                r_state   <= ST_HUNT;
                                r_bit_cnt <= '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bit_vld) begin
                        r_bit_cnt <= w_cnt_next;
                        if (w_byte_end && w_payload) begin
                            r_byte_out <= w_byte;
                            r_byte_vld <= 1'b1;
                            r_sof      <= w_first;
                        end
                        if (w_slot) begin
                            if (w_match) begin
                                r_miss <= '0;
                            end else begin
                                r_miss <= w_miss_inc;
                                if (w_miss_inc == c_miss_n) begin
                                    r_state   <= ST_HUNT;
                                    r_locked  <= 1'b0;
                                    r_bit_cnt <= '0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= ST_HUNT;
                    r_locked  <= 1'b0;
                    r_bit_cnt <= '0;
                    r_hit     <= '0;
                    r_miss    <= '0;
                end
            endcase
        end
    end

`ifdef CDR_FRAME_SYNC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of sync-slot misses seen while locked
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (r_state == ST_LOCKED && bit_vld && w_slot && !w_match
                     && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign byte_out = r_byte_out;
    assign byte_vld = r_byte_vld;
    assign sof      = r_sof;
    assign locked   = r_locked;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cdr_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdr_frame_sync
// Description : Table-driven bench for cdr_frame_sync (default parameters).
//               Each table row is one byte on the wire with the expected
//               state and output after its last bit; the table is replayed
//               back-to-back and with random idle gaps between strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdr_frame_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_vld;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       sof;
    logic       locked;
    logic [1:0] state;
    logic [7:0] err_cnt;

    cdr_frame_sync dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .byte_out (byte_out),
        .byte_vld (byte_vld),
        .sof      (sof),
        .locked   (locked),
        .state    (state),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [1:0] st;
        logic       vld;
        logic       sf;
        logic [7:0] dout;
        logic [7:0] misses;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vld_seen = 0;

    // Count every byte_vld pulse so stray output is caught anywhere
    always @(negedge clk) begin
        if (byte_vld === 1'b1) vld_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_err(input logic [7:0] n);
`ifdef CDR_FRAME_SYNC_ERRCNT_EN
        return n;
`else
        return 8'd0;
`endif
    endfunction

    task automatic add(input logic [7:0] d, input logic [1:0] st, input logic v,
                       input logic sf, input logic [7:0] o, input logic [7:0] m);
        vec_t r;
        r.din = d; r.st = st; r.vld = v; r.sf = sf; r.dout = o; r.misses = m;
        tbl.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the consuming posedge
    task automatic send_bit(input logic b, input int gap);
        bit_vld = 1'b1;
        bit_in  = b;
        @(negedge clk);
        bit_vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input int maxgap);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i], (i == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bit_vld = 1'($urandom_range(0, 1));
            bit_in  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst     = 1'b0;
        bit_vld = 1'b0;
        check("rst_state",    32'(state),    32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_byte_vld", 32'(byte_vld), 32'd0);
        check("rst_sof",      32'(sof),      32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
    endtask

    task automatic run_table(input int maxgap);
        int base;
        int exp_vld;
        int exp_sof;
        int sof_seen;
        do_reset();
        base     = vld_seen;
        exp_vld  = 0;
        exp_sof  = 0;
        sof_seen = 0;
        for (int k = 0; k < tbl.size(); k++) begin
            send_byte(tbl[k].din, maxgap);
            check($sformatf("row%0d_state", k),  32'(state),    32'(tbl[k].st));
            check($sformatf("row%0d_locked", k), 32'(locked),   32'(tbl[k].st == 2'd2));
            check($sformatf("row%0d_vld", k),    32'(byte_vld), 32'(tbl[k].vld));
            check($sformatf("row%0d_sof", k),    32'(sof),      32'(tbl[k].sf));
            if (tbl[k].vld)
                check($sformatf("row%0d_byte", k), 32'(byte_out), 32'(tbl[k].dout));
            check($sformatf("row%0d_err", k),    32'(err_cnt),  32'(exp_err(tbl[k].misses)));
            if (sof === 1'b1) sof_seen++;
            if (tbl[k].vld) exp_vld++;
            if (tbl[k].sf)  exp_sof++;
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
        check("total_byte_vld", 32'(vld_seen - base), 32'(exp_vld));
        check("total_sof",      32'(sof_seen),         32'(exp_sof));
    endtask

    initial begin
        rst     = 1'b1;
        bit_vld = 1'b0;
        bit_in  = 1'b0;

        // Acquisition: first D5 -> VERIFY, two slot matches -> LOCKED
        add(8'hD5, 2'd1, 0, 0, 8'h00, 0);
        add(8'h11, 2'd1, 0, 0, 8'h00, 0);
        add(8'h22, 2'd1, 0, 0, 8'h00, 0);
        add(8'h33, 2'd1, 0, 0, 8'h00, 0);
        add(8'h44, 2'd1, 0, 0, 8'h00, 0);
        add(8'hD5, 2'd1, 0, 0, 8'h00, 0);
        add(8'h55, 2'd1, 0, 0, 8'h00, 0);
        add(8'h66, 2'd1, 0, 0, 8'h00, 0);
        add(8'h77, 2'd1, 0, 0, 8'h00, 0);
        add(8'h88, 2'd1, 0, 0, 8'h00, 0);
        add(8'hD5, 2'd2, 0, 0, 8'h00, 0);
        add(8'h01, 2'd2, 1, 1, 8'h01, 0);
        add(8'h02, 2'd2, 1, 0, 8'h02, 0);
        add(8'h03, 2'd2, 1, 0, 8'h03, 0);
        add(8'h04, 2'd2, 1, 0, 8'h04, 0);
        // Single miss: flywheel keeps lock
        add(8'hD4, 2'd2, 0, 0, 8'h00, 1);
        add(8'hA1, 2'd2, 1, 1, 8'hA1, 1);
        add(8'hA2, 2'd2, 1, 0, 8'hA2, 1);
        add(8'hA3, 2'd2, 1, 0, 8'hA3, 1);
        add(8'hA4, 2'd2, 1, 0, 8'hA4, 1);
        add(8'hD5, 2'd2, 0, 0, 8'h00, 1);
        add(8'hB1, 2'd2, 1, 1, 8'hB1, 1);
        add(8'hB2, 2'd2, 1, 0, 8'hB2, 1);
        add(8'hB3, 2'd2, 1, 0, 8'hB3, 1);
        add(8'hB4, 2'd2, 1, 0, 8'hB4, 1);
        // Two consecutive misses: lose lock, last payload byte still emitted
        add(8'hD4, 2'd2, 0, 0, 8'h00, 2);
        add(8'hC1, 2'd2, 1, 1, 8'hC1, 2);
        add(8'hC2, 2'd2, 1, 0, 8'hC2, 2);
        add(8'hC3, 2'd2, 1, 0, 8'hC3, 2);
        add(8'hC4, 2'd2, 1, 0, 8'hC4, 2);
        add(8'hD4, 2'd0, 0, 0, 8'h00, 3);
        add(8'h00, 2'd0, 0, 0, 8'h00, 3);
        // False sync: bad first slot returns to HUNT
        add(8'hD5, 2'd1, 0, 0, 8'h00, 3);
        add(8'h11, 2'd1, 0, 0, 8'h00, 3);
        add(8'h22, 2'd1, 0, 0, 8'h00, 3);
        add(8'h33, 2'd1, 0, 0, 8'h00, 3);
        add(8'h44, 2'd1, 0, 0, 8'h00, 3);
        add(8'h00, 2'd0, 0, 0, 8'h00, 3);
        // Re-acquisition
        add(8'hD5, 2'd1, 0, 0, 8'h00, 3);
        add(8'h01, 2'd1, 0, 0, 8'h00, 3);
        add(8'h02, 2'd1, 0, 0, 8'h00, 3);
        add(8'h03, 2'd1, 0, 0, 8'h00, 3);
        add(8'h04, 2'd1, 0, 0, 8'h00, 3);
        add(8'hD5, 2'd1, 0, 0, 8'h00, 3);
        add(8'h05, 2'd1, 0, 0, 8'h00, 3);
        add(8'h06, 2'd1, 0, 0, 8'h00, 3);
        add(8'h07, 2'd1, 0, 0, 8'h00, 3);
        add(8'h08, 2'd1, 0, 0, 8'h00, 3);
        add(8'hD5, 2'd2, 0, 0, 8'h00, 3);
        add(8'h09, 2'd2, 1, 1, 8'h09, 3);
        add(8'h0A, 2'd2, 1, 0, 8'h0A, 3);
        add(8'h0B, 2'd2, 1, 0, 8'h0B, 3);
        add(8'h0C, 2'd2, 1, 0, 8'h0C, 3);
        add(8'hD5, 2'd2, 0, 0, 8'h00, 3);

        run_table(5);
        run_table(0);

        // Reset while LOCKED, in the middle of a payload byte
        for (int i = 7; i >= 4; i--) send_bit(1'b1, 0);
        rst     = 1'b1;
        bit_vld = 1'b1;
        bit_in  = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        bit_vld = 1'b0;
        check("midrst_state",    32'(state),    32'd0);
        check("midrst_byte_vld", 32'(byte_vld), 32'd0);
        check("midrst_locked",   32'(locked),   32'd0);
        check("midrst_err_cnt",  32'(err_cnt),  32'd0);
        repeat (3) @(negedge clk);
        check("midrst_idle_state", 32'(state), 32'd0);
        send_byte(8'hD5, 0);
        check("midrst_reacq_state", 32'(state), 32'd1);
        check("midrst_reacq_vld",   32'(byte_vld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
